mul_result_stage: RTL and testbench

MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_res_fifo.sv | 64 ++++++
 rtl/mul_result_stage.sv | 109 ++++++++++
 tb/tb_mul_result_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result stage.
// Holds the op encodings and the output buffer depth.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mul_res_fifo.sv
// Small result buffer with valid/ready on both sides; output registered, zero when empty.
// Latency 1 cycle push-to-valid; accepts when not full or when the head pops the same cycle.
module mul_res_fifo
  import mul_pkg::*;
#(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign in_ready  = (count != CNT_W'(FIFO_DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/mul_result_stage.sv
// Sign-fixes the multiplier magnitude product and selects the low or high half (S1 regs, S2 result, 2-deep FIFO).
// Latency 2 cycles accept-to-out_valid; S1/S2 hold and in_ready drops when the FIFO is full and not popping.
module mul_result_stage
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] high,
  input  logic [XLEN-1:0] low,
  input  logic            neg,
  input  logic [1:0]      op,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int EW = XLEN + 5;

  logic            s1_vld;
  logic [XLEN-1:0] s1_high;
  logic [XLEN-1:0] s1_low;
  logic            s1_neg;
  mul_op_e         s1_op;
  logic [4:0]      s1_rd;

  logic            s2_vld;
  logic [XLEN-1:0] s2_res;
  logic [4:0]      s2_rd;

  logic            fifo_rdy;
  logic            s2_adv;
  logic            s1_ld;
  logic [2*XLEN-1:0] mag;
  logic [2*XLEN-1:0] prod;
  logic            neg_eff;
  logic [XLEN-1:0] s1_res;
  logic [EW-1:0]   fifo_out;

  assign s2_adv   = !s2_vld || fifo_rdy;
  assign s1_ld    = !s1_vld || s2_adv;
  assign in_ready = rst_n && s1_ld;

  // Full-width negate so the borrow out of the low half reaches the high half.
  always_comb begin
    mag     = {s1_high, s1_low};
    neg_eff = s1_neg && (s1_op != OP_MULHU);
    prod    = neg_eff ? (~mag + (2*XLEN)'(1)) : mag;
    s1_res  = (s1_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_high <= '0;
      s1_low  <= '0;
      s1_neg  <= 1'b0;
      s1_op   <= OP_MUL;
      s1_rd   <= '0;
      s2_vld  <= 1'b0;
      s2_res  <= '0;
      s2_rd   <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_res <= s1_res;
          s2_rd  <= s1_rd;
        end
      end
      if (s1_ld) begin
        s1_vld <= in_valid;
        if (in_valid) begin
          s1_high <= high;
          s1_low  <= low;
          s1_neg  <= neg;
          s1_op   <= mul_op_e'(op);
          s1_rd   <= rd_in;
        end
      end
    end
  end

  mul_res_fifo #(
    .W(EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (s2_vld),
    .in_ready (fifo_rdy),
    .in_data  ({s2_res, s2_rd}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_out)
  );

  assign {result, rd_out} = fifo_out;

endmodule

// File: tb/tb_mul_result_stage.sv
// Randomized and directed bench for mul_result_stage against a queue-based reference model.
module tb_mul_result_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] high = '0;
  logic [XLEN-1:0] low = '0;
  logic            neg = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [4:0]      rd_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pop = 0;

  mul_result_stage #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .high     (high),
    .low      (low),
    .neg      (neg),
    .op       (op),
    .rd_in    (rd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Signed value of the product as plain 64-bit arithmetic, then pick the half.
  function automatic logic [XLEN-1:0] ref_result(input logic [XLEN-1:0] h, input logic [XLEN-1:0] l,
                                                 input logic n, input logic [1:0] o);
    logic [63:0] m;
    logic [63:0] v;
    m = {h, l};
    v = (n && o != 2'b11) ? (64'd0 - m) : m;
    return (o == 2'b00) ? v[31:0] : v[63:32];
  endfunction

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          check_eq("result", result, q[0].res);
          check_eq("rd_out", {27'b0, rd_out}, {27'b0, q[0].rd});
          if (out_ready && !flush) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end else begin
        check_eq("idle_result", result, 32'd0);
        check_eq("idle_rd_out", {27'b0, rd_out}, 32'd0);
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_result(high, low, neg, op), rd_in});
    end
  end

  task automatic rand_fields();
    high  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    low   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    neg   = 1'($urandom_range(0, 1));
    op    = 2'($urandom_range(0, 3));
    rd_in = 5'($urandom_range(0, 31));
  endtask

  // All directed tasks start and end 1 time unit after a rising edge.
  task automatic do_one(input string tag, input logic [31:0] h, input logic [31:0] l, input logic n,
                        input logic [1:0] o, input logic [4:0] rd, input logic [31:0] exp);
    in_valid = 1'b1; high = h; low = l; neg = n; op = o; rd_in = rd;
    #1 check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat0"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
    check_eq(tag, result, exp);
    check_eq({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
  endtask

  task automatic fill(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      rand_fields();
      #1 check_eq({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int p0;
    #12;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_rd_out", {27'b0, rd_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    do_one("mul_neg", 32'h0, 32'h6, 1'b1, 2'b00, 5'd3, 32'hFFFF_FFFA);
    do_one("mulh_carry", 32'h1, 32'h0, 1'b1, 2'b01, 5'd7, 32'hFFFF_FFFF);
    do_one("mulhu_ign_neg", 32'h8000_0000, 32'h5, 1'b1, 2'b11, 5'd9, 32'h8000_0000);
    do_one("mulhsu_pos", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2'b10, 5'd31, 32'h1234_5678);
    do_one("mulh_neg", 32'h0, 32'h1, 1'b1, 2'b01, 5'd1, 32'hFFFF_FFFF);
    drain("drain_directed");

    // Backpressure: four accepted, then the stage must refuse more.
    out_ready = 1'b0;
    p0 = n_pop;
    fill("bp", 4);
    check_eq("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
    check_eq("bp_head", result, q[0].res);
    drain("bp_drain");
    check_eq("bp_count", 32'(n_pop - p0), 32'd4);

    // Flush with pipe and FIFO full; the flush-cycle input is dropped.
    out_ready = 1'b0;
    fill("fl", 4);
    flush = 1'b1; in_valid = 1'b1; rand_fields();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("flush_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rand_fields();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;
    drain("rand_drain");

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    fill("ar", 3);
    repeat (2) @(posedge clk);
    #1 check_eq("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("ar_result", result, 32'd0);
    check_eq("ar_rd_out", {27'b0, rd_out}, 32'd0);
    check_eq("ar_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check_eq("ar_post_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("ar_no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
